// File: rtl/mmio_seg_key.sv
// mmio_seg_key: MMIO-mapped multiplexed seven-segment display driver with a debounced key-code capture register.
module mmio_seg_key #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 16,
  parameter int KEY_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [1:0]        addr,
  input  logic [15:0]       in,
  input  logic              wEna,
  input  logic              rEna,
  output logic [15:0]       out,
  input  logic [KEY_W-1:0]  inPKey,
  output logic [7:0]        outPDisp,
  output logic [DIGITS-1:0] outPCtrl
);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE);
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0]      disp_lo, disp_hi, ctrl, keystat, rdata;
  logic [KEY_W-1:0] s1, s2, last, stable, key_code;
  logic             key_valid, wr, rd, settled, capture, blank, dp;
  logic [BW-1:0]    db_cnt;
  logic [SW-1:0]    scan_cnt;
  logic [DW-1:0]    digit;
  logic [3:0]       nib;
  assign wr      = sel & wEna;
  assign rd      = sel & rEna;
  assign keystat = {key_valid, 15'(key_code)};
  assign rdata   = addr == 2'd0 ? disp_lo : addr == 2'd1 ? disp_hi : addr == 2'd2 ? ctrl : keystat;
  // last holds the code currently being timed; settled once it survived the full count
  assign settled = s2 == last && db_cnt == BW'(DEBOUNCE - 1);
  assign capture = settled && last != stable && last != '0;
  assign nib      = 4'({disp_hi, disp_lo} >> {digit, 2'b00});
  assign blank    = 1'(ctrl[7:0] >> digit);
  assign dp       = 1'(ctrl[15:8] >> digit);
  assign outPDisp = blank ? 8'hFF : ~{dp, HEX[nib]};
  assign outPCtrl = ~(DIGITS'(1) << digit);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_lo   <= '0;
      disp_hi   <= '0;
      ctrl      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      out       <= '0;
      s1        <= '0;
      s2        <= '0;
      last      <= '0;
      stable    <= '0;
      db_cnt    <= '0;
      scan_cnt  <= '0;
      digit     <= '0;
    end else begin
      s1 <= inPKey;
      s2 <= s1;
      if (s2 != last) begin
        last   <= s2;
        db_cnt <= '0;
      end else if (!settled) db_cnt <= db_cnt + 1'b1;
      if (settled) stable <= last;
      if (capture) key_code <= last;
      // a fresh capture outranks a clearing read on the same edge
      if (capture) key_valid <= 1'b1;
      else if (rd && addr == 2'd3) key_valid <= 1'b0;
      if (rd) out <= rdata;
      if (wr && addr == 2'd0) disp_lo <= in;
      if (wr && addr == 2'd1) disp_hi <= in;
      if (wr && addr == 2'd2) ctrl <= in;
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= digit == DW'(DIGITS - 1) ? '0 : digit + 1'b1;
      end else scan_cnt <= scan_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mmio_seg_key.sv
// tb_mmio_seg_key: randomized self-checking bench for mmio_seg_key (4-digit and 8-digit instances).
module tb_mmio_seg_key;
  logic        clk = 0, rst = 0, sel = 0, wEna = 0, rEna = 0;
  logic [1:0]  addr = 0;
  logic [15:0] din = 0, out4, out8;
  logic [6:0]  key = 0;
  logic [7:0]  disp4, disp8, ctrl8;
  logic [3:0]  ctrl4;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] m_lo = 0, m_hi = 0, m_ctrl = 0, exp_out = 0;
  logic [6:0]  m_code = 0;
  logic        m_valid = 0;
  logic [6:0]  hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  mmio_seg_key #(.DIGITS(4), .SCAN_DIV(4), .DEBOUNCE(4), .KEY_W(7)) u4 (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .in(din), .wEna(wEna), .rEna(rEna),
    .out(out4), .inPKey(key), .outPDisp(disp4), .outPCtrl(ctrl4));
  mmio_seg_key #(.DIGITS(8), .SCAN_DIV(4), .DEBOUNCE(4), .KEY_W(7)) u8 (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .in(din), .wEna(wEna), .rEna(rEna),
    .out(out8), .inPKey(key), .outPDisp(disp8), .outPCtrl(ctrl8));

  always #5 clk = ~clk;
  // edges seen since reset release: the active digit is simply (cyc / SCAN_DIV) mod DIGITS
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [7:0] exp_seg(input int d);
    logic [31:0] v;
    v = {m_hi, m_lo};
    if (m_ctrl[d]) return 8'hFF;
    return ~{m_ctrl[8+d], hex[v[4*d +: 4]]};
  endfunction

  function automatic logic [15:0] model_reg(input logic [1:0] a);
    return a == 0 ? m_lo : a == 1 ? m_hi : a == 2 ? m_ctrl : {m_valid, 8'h00, m_code};
  endfunction

  task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [15:0] d);
    sel = 1; wEna = w; rEna = r; addr = a; din = d;
    @(negedge clk);
    sel = 0; wEna = 0; rEna = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus(1, 0, a, d);
    if (a == 0) m_lo = d;
    if (a == 1) m_hi = d;
    if (a == 2) m_ctrl = d;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e, input string nm);
    bus(0, 1, a, 16'h0);
    exp_out = e;
    n_cmp++;
    if (out4 !== e) begin
      n_bad++;
      $display("FAIL %s: out=%h want %h", nm, out4, e);
    end
  endtask

  task automatic check_scan(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      int d4, d8;
      @(negedge clk);
      d4 = (cyc / 4) % 4;
      d8 = (cyc / 4) % 8;
      n_cmp++;
      if (disp4 !== exp_seg(d4) || ctrl4 !== 4'(~(1 << d4))) begin
        n_bad++;
        $display("FAIL %s u4 cyc=%0d: disp=%h ctrl=%h want disp=%h ctrl=%h",
                 nm, cyc, disp4, ctrl4, exp_seg(d4), 4'(~(1 << d4)));
      end
      n_cmp++;
      if (disp8 !== exp_seg(d8) || ctrl8 !== 8'(~(1 << d8))) begin
        n_bad++;
        $display("FAIL %s u8 cyc=%0d: disp=%h ctrl=%h want disp=%h ctrl=%h",
                 nm, cyc, disp8, ctrl8, exp_seg(d8), 8'(~(1 << d8)));
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if (disp4 !== 8'hC0 || ctrl4 !== 4'hE || out4 !== 16'h0 || disp8 !== 8'hC0 || ctrl8 !== 8'hFE) begin
      n_bad++;
      $display("FAIL reset_outputs: disp4=%h ctrl4=%h out=%h disp8=%h ctrl8=%h want c0 e 0000 c0 fe",
               disp4, ctrl4, out4, disp8, ctrl8);
    end
    rst = 1;
    for (int a = 0; a < 4; a++) rd(2'(a), 16'h0, "reset_read");
  endtask

  task automatic test_scan;
    wr(0, 16'h12AF);
    wr(1, 16'h9876);
    wr(2, 16'h0000);
    check_scan(40, "scan");
  endtask

  task automatic test_blank_dp;
    wr(2, 16'h0102);
    check_scan(40, "blank_dp");
    repeat (4) begin
      wr(0, 16'($urandom));
      wr(1, 16'($urandom));
      wr(2, 16'($urandom));
      check_scan(36, "rand_disp");
    end
  endtask

  task automatic test_regs;
    bus(1, 1, 2, 16'hBEEF);
    n_cmp++;
    if (out4 !== m_ctrl) begin
      n_bad++;
      $display("FAIL rw_same_edge: out=%h want %h", out4, m_ctrl);
    end
    m_ctrl = 16'hBEEF;
    rd(2, 16'hBEEF, "rw_readback");
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  a;
      logic [15:0] d;
      logic        w, r;
      a = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      bus(w, r, a, d);
      if (r) exp_out = model_reg(a);
      if (r && a == 3) m_valid = 0;
      if (w && a == 0) m_lo = d;
      if (w && a == 1) m_hi = d;
      if (w && a == 2) m_ctrl = d;
      n_cmp++;
      if (out4 !== exp_out) begin
        n_bad++;
        $display("FAIL rand_reg a=%0d w=%0d r=%0d: out=%h want %h", a, w, r, out4, exp_out);
      end
    end
  endtask

  task automatic test_debounce;
    for (int i = 0; i < 12; i++) begin
      key = ((i / 2) % 2 == 0) ? 7'h41 : 7'h00;
      @(negedge clk);
    end
    key = 7'h41;
    rd(3, 16'h0000, "debounce_toggle");
    repeat (3) @(negedge clk);
    rd(3, 16'h0000, "debounce_early");
    repeat (5) @(negedge clk);
    rd(3, 16'h8041, "debounce_capture");
    rd(3, 16'h0041, "debounce_cleared");
  endtask

  task automatic test_collision;
    logic found;
    found = 0;
    key = 7'h05;
    for (int i = 0; i < 20 && !found; i++) begin
      bus(0, 1, 3, 16'h0);
      n_cmp++;
      if (out4 === 16'h8005) found = 1;
      else if (out4 !== 16'h0041) begin
        n_bad++;
        $display("FAIL collision_old: out=%h want 0041", out4);
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL collision_capture: no 8005 within 20 reads, last out=%h", out4);
    end
    rd(3, 16'h0005, "collision_clear");
    key = 7'h00;
    repeat (12) @(negedge clk);
    rd(3, 16'h0005, "release_no_capture");
  endtask

  task automatic test_reset_mid;
    wr(0, 16'hFFFF);
    key = 7'h22;
    repeat (6) @(negedge clk);
    rst = 0;
    key = 7'h00;
    #1;
    n_cmp++;
    if (disp4 !== 8'hC0 || ctrl4 !== 4'hE || out4 !== 16'h0 || disp8 !== 8'hC0 || ctrl8 !== 8'hFE) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: disp4=%h ctrl4=%h out=%h disp8=%h ctrl8=%h want c0 e 0000 c0 fe",
               disp4, ctrl4, out4, disp8, ctrl8);
    end
    m_lo = 0; m_hi = 0; m_ctrl = 0; m_code = 0; m_valid = 0;
    @(negedge clk);
    rst = 1;
    for (int a = 0; a < 4; a++) rd(2'(a), 16'h0, "reset_mid_read");
    check_scan(20, "reset_mid_scan");
    repeat (12) @(negedge clk);
    rd(3, 16'h0000, "reset_mid_key");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_blank_dp();
    test_regs();
    test_debounce();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_seg_key.md
MMIO_SEG_KEY -- requirements
Module: mmio_seg_key

Interface
REQ-001 Parameter DIGITS, default 4: number of seven-segment digits scanned, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles each digit stays enabled, minimum 2.
REQ-003 Parameter DEBOUNCE, default 16: clk cycles a key code must stay stable before capture, minimum 2.
REQ-004 Parameter KEY_W, default 7: key input width, legal range 1..15.
REQ-005 One clock, clk; reset is asynchronous and active-low, rst.
REQ-006 Port: clk  input  1  rising-edge clock.
REQ-007 Port: rst  input  1  asynchronous active-low reset.
REQ-008 Port: sel  input  1  external address decode hit for this block.
REQ-009 Port: addr  input  2  register index.
REQ-010 Port: in  input  16  write data.
REQ-011 Port: wEna  input  1  write strobe, qualified by sel.
REQ-012 Port: rEna  input  1  read strobe, qualified by sel.
REQ-013 Port: out  output  16  registered read data.
REQ-014 Port: inPKey  input  KEY_W  raw asynchronous key code, 0 means no key.
REQ-015 Port: outPDisp  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-016 Port: outPCtrl  output  DIGITS  one-hot digit enables, active-low.

Function
REQ-017 Register map: 0 DISP_LO (hex nibbles, digits 0-3), 1 DISP_HI (digits 4-7), 2 CTRL (bits[7:0] blank mask, bits[15:8] decimal-point mask), 3 KEYSTAT, read-only {key_valid, zeros, key_code}.
REQ-018 A write occurs on a clk edge with sel=1 and wEna=1; the register updates that edge, and writes to index 3 are ignored.
REQ-019 Register bits for digits at index DIGITS or above SHALL be stored and read back but never displayed.
REQ-020 Read: with sel=1 and rEna=1 at edge N, out holds the addressed register value from edge N until the next qualified read.
REQ-021 A read of index 3 with key_valid=1 clears key_valid at the same edge; out returns the pre-clear value with bit15=1.
REQ-022 Scan: a counter runs 0..SCAN_DIV-1; at terminal count the active digit advances by one and wraps from DIGITS-1 to 0.
REQ-023 Active digit i: outPCtrl bit i=0 and all other bits=1; outPDisp = ~{dp[i], hex7seg(nibble i)}.
REQ-024 If blank[i]=1 while digit i is active, outPDisp=8'hFF, outPCtrl is unchanged, and scan timing is unaffected.
REQ-025 Hex decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-026 inPKey passes through a 2-flop synchroniser before any use.
REQ-027 Debounce: a stability counter resets whenever the synchronised code changes; a code held DEBOUNCE consecutive cycles becomes the stable code.
REQ-028 Capture: when the stable code changes to a nonzero value, key_code loads it and key_valid is set, and any unread key_valid is overwritten.
REQ-029 Release: a stable code of 0 does not capture and does not change key_code or key_valid.
REQ-030 If capture and a clearing read of index 3 occur at the same edge, capture wins: key_valid=1 with the new code, and out shows the old value.
REQ-031 A writer writing while reading at the same edge SHALL perform both operations; out shows the pre-write value.

Reset
REQ-032 rst=0 asynchronously clears DISP_LO, DISP_HI, CTRL, key_code, key_valid, out, the scan counter, the debounce state and both synchroniser flops to 0, and sets the active digit to 0.
REQ-033 During reset and after it, outPCtrl = ~1 (digit 0 enabled) and outPDisp = ~{0, 7'h3F}.
REQ-034 Reset asserted mid-scan or mid-debounce aborts the operation; no capture follows release unless the full DEBOUNCE count is met again.

Verification
REQ-035 Scan scenario: DIGITS=4, SCAN_DIV=4, write DISP_LO=16'h12AF -> outPCtrl steps E,D,B,7 every 4 cycles; outPDisp steps ~71, ~77, ~5B, ~06 (digit 0 first), then wraps to E.
REQ-036 Blank/dp scenario: CTRL=16'h0102 -> digit 1 outPDisp=FF, digit 0 shows dp low (bit7=0), and the period is unchanged.
REQ-037 Debounce scenario: DEBOUNCE=4, inPKey=7'h41 toggling every 2 cycles, then held -> no capture while toggling; exactly one capture after hold; read 3 returns 16'h8041 and a second read returns 16'h0041.
REQ-038 Collision scenario: read index 3 on the same edge capture fires for 7'h05 -> out shows the old value; the next read returns 16'h8005.
REQ-039 Reset scenario: rst low for 1 cycle mid-scan with DISP_LO=16'hFFFF -> outputs immediately match REQ-033 and all reads return 0.
REQ-040 Parameter scenario: DIGITS=8, DISP_HI=16'h9876 -> digits 4-7 show 6,7,8,9 and outPCtrl is 8 bits one-hot-low.
